// File: rtl/half_subtractor.sv
// rtl/half_subtractor.sv - bitwise half subtractor with registered, valid-qualified copy and saturating borrow counter
//
// Ports:
//   clk          rising-edge clock for the registered outputs
//   rst_n        asynchronous active-low reset of all registered state
//   a, b         minuend / subtrahend lanes (WIDTH independent lanes)
//   in_valid     qualifies a/b for the registered path and the counter
//   clr_cnt      synchronous clear of borrow_cnt, wins over increment
//   diff         combinational a ^ b
//   borrow       combinational ~a & b
//   diff_q       registered diff of the last accepted operands
//   borrow_q     registered borrow of the last accepted operands
//   valid_q      one-cycle pulse after each accepted input
//   borrow_any_q registered OR of borrow for the last accepted operands
//   borrow_cnt   saturating count of accepted cycles with any borrow lane set

module half_subtractor #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] diff,
    output logic [WIDTH-1:0] borrow,
    output logic [WIDTH-1:0] diff_q,
    output logic [WIDTH-1:0] borrow_q,
    output logic             valid_q,
    output logic             borrow_any_q,
    output logic [CNT_W-1:0] borrow_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             borrow_any;
    logic [WIDTH-1:0] diff_d;
    logic [WIDTH-1:0] borrow_d;
    logic             valid_d;
    logic             borrow_any_d;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Each lane is an independent half subtractor; no borrow ripples between lanes.
    assign diff       = a ^ b;
    assign borrow     = ~a & b;
    assign borrow_any = |borrow;
    assign borrow_cnt = cnt_q;

    always_comb begin
        diff_d       = diff_q;
        borrow_d     = borrow_q;
        borrow_any_d = borrow_any_q;
        valid_d      = in_valid;
        cnt_d        = cnt_q;

        if (in_valid) begin
            diff_d       = diff;
            borrow_d     = borrow;
            borrow_any_d = borrow_any;
        end

        // Clear beats increment; the counter sticks at all-ones instead of wrapping.
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (in_valid && borrow_any && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q       <= '0;
            borrow_q     <= '0;
            valid_q      <= 1'b0;
            borrow_any_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            diff_q       <= diff_d;
            borrow_q     <= borrow_d;
            valid_q      <= valid_d;
            borrow_any_q <= borrow_any_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_half_subtractor.sv
// tb/tb_half_subtractor.sv - self-checking bench for half_subtractor

module tb_half_subtractor;

    logic       clk;
    logic       rst_n;

    // WIDTH=4, CNT_W=2 instance
    logic [3:0] a, b;
    logic       in_valid, clr_cnt;
    logic [3:0] diff, borrow, diff_q, borrow_q;
    logic       valid_q, borrow_any_q;
    logic [1:0] borrow_cnt;

    // WIDTH=1, default CNT_W instance
    logic       a1, b1;
    logic       diff1, borrow1, diff_q1, borrow_q1, valid_q1, borrow_any_q1;
    logic [7:0] borrow_cnt1;

    half_subtractor #(.WIDTH(4), .CNT_W(2)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a            (a),
        .b            (b),
        .in_valid     (in_valid),
        .clr_cnt      (clr_cnt),
        .diff         (diff),
        .borrow       (borrow),
        .diff_q       (diff_q),
        .borrow_q     (borrow_q),
        .valid_q      (valid_q),
        .borrow_any_q (borrow_any_q),
        .borrow_cnt   (borrow_cnt)
    );

    half_subtractor #(.WIDTH(1), .CNT_W(8)) u_w1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .a            (a1),
        .b            (b1),
        .in_valid     (1'b0),
        .clr_cnt      (1'b0),
        .diff         (diff1),
        .borrow       (borrow1),
        .diff_q       (diff_q1),
        .borrow_q     (borrow_q1),
        .valid_q      (valid_q1),
        .borrow_any_q (borrow_any_q1),
        .borrow_cnt   (borrow_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       v;
        logic       clr;
        logic [3:0] ed;
        logic [3:0] eb;
    } vec_t;

    typedef struct {
        logic       valid;
        logic [3:0] d;
        logic [3:0] bw;
        logic       any;
        logic [1:0] cnt;
    } exp_t;

    exp_t sb[$];

    // Reference state for the registered path
    logic [3:0] m_diff, m_borrow;
    logic       m_any;
    int         m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_diff   = '0;
        m_borrow = '0;
        m_any    = 1'b0;
        m_cnt    = 0;
    endtask

    // Drive one cycle of stimulus, check comb outputs, then compare registered outputs after the edge
    task automatic apply(input logic [3:0] av, input logic [3:0] bv, input logic v, input logic c,
                         input logic [3:0] ed, input logic [3:0] eb, input string tag);
        exp_t e;
        logic [3:0] bw;
        a = av; b = bv; in_valid = v; clr_cnt = c;
        bw = ~av & bv;
        if (v) begin
            m_diff   = av ^ bv;
            m_borrow = bw;
            m_any    = |bw;
        end
        if (c) m_cnt = 0;
        else if (v && (|bw) && m_cnt < 3) m_cnt++;
        e.valid = v; e.d = m_diff; e.bw = m_borrow; e.any = m_any; e.cnt = 2'(m_cnt);
        sb.push_back(e);
        #1;
        chk({tag, ".diff"}, diff, ed);
        chk({tag, ".borrow"}, borrow, eb);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s.sb: got empty scoreboard expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".valid_q"}, valid_q, e.valid);
            chk({tag, ".diff_q"}, diff_q, e.d);
            chk({tag, ".borrow_q"}, borrow_q, e.bw);
            chk({tag, ".borrow_any_q"}, borrow_any_q, e.any);
            chk({tag, ".borrow_cnt"}, borrow_cnt, e.cnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[10];
    logic [1:0] sw_ab [4];
    logic [1:0] sw_exp[4];
    logic [1:0] sat_exp[5];

    initial begin
        vecs[0] = '{4'b1010, 4'b0110, 1'b1, 1'b0, 4'b1100, 4'b0100};
        vecs[1] = '{4'b0001, 4'b0000, 1'b1, 1'b0, 4'b0001, 4'b0000};
        vecs[2] = '{4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0001};
        vecs[3] = '{4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0001};
        vecs[4] = '{4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0001};
        vecs[5] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0000};
        vecs[6] = '{4'b0101, 4'b1010, 1'b1, 1'b0, 4'b1111, 4'b1010};
        vecs[7] = '{4'b0000, 4'b1111, 1'b1, 1'b0, 4'b1111, 4'b1111};
        vecs[8] = '{4'b0000, 4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0001};
        vecs[9] = '{4'b0000, 4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0001};
        sw_ab[0] = 2'b00; sw_exp[0] = 2'b00;
        sw_ab[1] = 2'b01; sw_exp[1] = 2'b11;
        sw_ab[2] = 2'b10; sw_exp[2] = 2'b10;
        sw_ab[3] = 2'b11; sw_exp[3] = 2'b00;
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

        rst_n = 1'b0; a = '0; b = '0; in_valid = 1'b0; clr_cnt = 1'b0; a1 = 1'b0; b1 = 1'b0;
        model_reset();
        #2;
        chk("rst.diff_q", diff_q, 4'b0);
        chk("rst.borrow_q", borrow_q, 4'b0);
        chk("rst.valid_q", valid_q, 1'b0);
        chk("rst.borrow_any_q", borrow_any_q, 1'b0);
        chk("rst.borrow_cnt", borrow_cnt, 2'd0);
        chk("rst.w1_regs", {diff_q1, borrow_q1, valid_q1, borrow_any_q1, borrow_cnt1}, 12'h0);

        // WIDTH=1 truth-table sweep, comb outputs only (in_valid tied low)
        for (int i = 0; i < 4; i++) begin
            {a1, b1} = sw_ab[i];
            #1;
            chk($sformatf("w1.sweep%0d", i), {diff1, borrow1}, sw_exp[i]);
            #99;
        end
        chk("w1.regs_idle", {diff_q1, borrow_q1, valid_q1, borrow_any_q1, borrow_cnt1}, 12'h0);

        @(posedge clk);
        #1 rst_n = 1'b1;

        // Main vector table: single accept, hold, no-borrow, back-to-back, saturation, clear priority
        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].v, vecs[i].clr, vecs[i].ed, vecs[i].eb,
                  $sformatf("vec%0d", i));
        end

        // Saturation sequence from zero: 1,2,3,3,3
        for (int i = 0; i < 5; i++) begin
            apply(4'b0000, 4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0001, $sformatf("sat%0d", i));
            chk($sformatf("sat%0d.cnt_const", i), borrow_cnt, sat_exp[i]);
        end
        apply(4'b0000, 4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0001, "satclr");
        chk("satclr.cnt_const", borrow_cnt, 2'd0);

        // Async reset between edges after the counter reaches 2
        apply(4'b0000, 4'b0010, 1'b1, 1'b0, 4'b0010, 4'b0010, "pre_rst0");
        apply(4'b0000, 4'b0100, 1'b1, 1'b0, 4'b0100, 4'b0100, "pre_rst1");
        chk("pre_rst.cnt_const", borrow_cnt, 2'd2);
        a = 4'b1010; b = 4'b0110; in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst.diff_q", diff_q, 4'b0);
        chk("arst.borrow_q", borrow_q, 4'b0);
        chk("arst.valid_q", valid_q, 1'b0);
        chk("arst.borrow_any_q", borrow_any_q, 1'b0);
        chk("arst.borrow_cnt", borrow_cnt, 2'd0);
        chk("arst.diff", diff, 4'b1100);
        chk("arst.borrow", borrow, 4'b0100);
        #1 rst_n = 1'b1;
        model_reset();

        // First accept after release behaves as after power-up
        apply(4'b0000, 4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0001, "post_rst");
        chk("post_rst.cnt_const", borrow_cnt, 2'd1);
        apply(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, "post_idle");
        chk("post_idle.valid_const", valid_q, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
